// File: rtl/req_gnt_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// req/gnt responder.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    COOL  = 2'd3
  } state_e;

  localparam int DEF_DLY_W    = 4;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_CNT_W    = 8;
  localparam int HOLD_W       = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/req_gnt_sat_counter.sv
// Saturating event counter: counts inc pulses up to all-ones and sticks there.
module req_gnt_sat_counter
  import req_gnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = CNT_W'(sat_inc(32'(cnt_reg), CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/req_gnt_responder.sv
// Grant side of the req/gnt handshake: programmable grant latency, hold limit
// with timeout pulse, one-cycle cool-down. REQ_GNT_RESPONDER_SVA_EN adds assertions.
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int DLY_W    = DEF_DLY_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             busy,
  input  logic [DLY_W-1:0] dly,
  output logic             gnt,
  output logic             timeout,
  output logic [CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  state_e            state_reg, state_next;
  logic [DLY_W-1:0]  dly_cnt_reg, dly_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              gnt_reg, gnt_next;
  logic              timeout_reg, timeout_next;
  logic              grant_inc, abort_inc;

  always_comb begin
    state_next    = state_reg;
    dly_cnt_next  = dly_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    grant_inc     = 1'b0;
    abort_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req && !busy) begin
          if (dly == '0) begin
            state_next    = GRANT;
            hold_cnt_next = HOLD_W'(1);
            grant_inc     = 1'b1;
          end else begin
            state_next   = WAIT;
            dly_cnt_next = dly;
          end
        end
      end
      WAIT: begin
        // Withdrawal wins over both busy and an expiring delay.
        if (!req) begin
          state_next   = IDLE;
          dly_cnt_next = '0;
          abort_inc    = 1'b1;
        end else if (!busy) begin
          if (dly_cnt_reg == DLY_W'(1)) begin
            state_next    = GRANT;
            dly_cnt_next  = '0;
            hold_cnt_next = HOLD_W'(1);
            grant_inc     = 1'b1;
          end else begin
            dly_cnt_next = dly_cnt_reg - DLY_W'(1);
          end
        end
      end
      GRANT: begin
        if (!req) begin
          state_next = COOL;
        end else if (hold_cnt_reg == HOLD_W'(MAX_HOLD)) begin
          state_next   = COOL;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      COOL: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt_next = (state_next == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dly_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      gnt_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dly_cnt_reg  <= dly_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {abort_inc, grant_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    req_gnt_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (cnt_inc[gi]),
      .cnt   (cnt_val[gi])
    );
  end

  assign gnt       = gnt_reg;
  assign timeout   = timeout_reg;
  assign grant_cnt = cnt_val[0];
  assign abort_cnt = cnt_val[1];

`ifdef REQ_GNT_RESPONDER_SVA_EN
  // Length of the current gnt-high run, excluding the cycle being sampled.
  logic [HOLD_W:0] sva_run_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sva_run_reg <= '0;
    end else if (gnt_reg) begin
      sva_run_reg <= sva_run_reg + (HOLD_W+1)'(1);
    end else begin
      sva_run_reg <= '0;
    end
  end

  a_rose_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(gnt_reg) |-> $past(req));
  a_hold_limit: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_reg |-> (sva_run_reg < (HOLD_W+1)'(MAX_HOLD)));
  a_timeout_on_fall: assert property (@(posedge clk) disable iff (!rst_n)
    timeout_reg |-> $fell(gnt_reg));
  a_cool_then_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == COOL) |=> (state_reg == IDLE));

  c_zero_dly_grant: cover property (@(posedge clk) disable iff (!rst_n)
    (state_reg == IDLE) && req && !busy && (dly == '0));
  c_timeout: cover property (@(posedge clk) disable iff (!rst_n) timeout_reg);
  c_abort: cover property (@(posedge clk) disable iff (!rst_n)
    (state_reg == WAIT) && !req);
`endif

endmodule
